// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave exposing a 32 x 8 register file (MAX3421E-style command byte),
// with a local read/write port and write strobes for SPI-originated writes.
module spi_slave_regfile #(
  parameter int unsigned NREGS       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW         = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  input  logic          spi_ss_n,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  input  logic [7:0]    status_in,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_active
);

  typedef enum logic [1:0] {IDLE, CMD, DATA_WR, DATA_RD} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_in;
  logic [7:0]    shift_out;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr;
  logic          wr_pending;
  logic [7:0]    wr_byte;
  logic [7:0]    regs [NREGS];

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync[0] <= spi_sclk;
      mosi_sync[0] <= spi_mosi;
      ss_sync[0]   <= spi_ss_n;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
      end
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign rx_byte   = {shift_in, mosi_s};

  // A falling edge always presents shift_out[7]; the status MSB is driven
  // directly at frame start so the first falling edge presents bit 6.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      wr_pending   <= 1'b0;
      wr_byte      <= '0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      frame_active <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      wr_valid <= 1'b0;
      // A completed byte commits even if SS_n has already risen.
      if (wr_pending) begin
        wr_pending <= 1'b0;
        wr_valid   <= 1'b1;
        wr_addr    <= addr;
        wr_data    <= wr_byte;
        addr       <= next_addr(addr);
      end
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state        <= CMD;
            bit_cnt      <= '0;
            spi_miso_oe  <= 1'b1;
            frame_active <= 1'b1;
            spi_miso     <= status_in[7];
            shift_out    <= {status_in[6:0], 1'b0};
          end
        end
        default: begin
          if (ss_s) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            spi_miso_oe  <= 1'b0;
            spi_miso     <= 1'b0;
            frame_active <= 1'b0;
          end else begin
            if (sclk_fall) begin
              spi_miso  <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= {shift_in[5:0], mosi_s};
              if (bit_cnt == 3'd7) begin
                case (state)
                  CMD: begin
                    addr <= rx_byte[7 -: AW];
                    if (rx_byte[1]) begin
                      state     <= DATA_WR;
                      shift_out <= '0;
                    end else begin
                      state     <= DATA_RD;
                      shift_out <= regs[rx_byte[7 -: AW]];
                    end
                  end
                  DATA_WR: begin
                    wr_pending <= 1'b1;
                    wr_byte    <= rx_byte;
                    shift_out  <= '0;
                  end
                  DATA_RD: begin
                    addr      <= next_addr(addr);
                    shift_out <= regs[next_addr(addr)];
                  end
                  default: ;
                endcase
              end
            end
          end
        end
      endcase
    end
  end

  // SPI commit is ordered after the local write so it wins on an address clash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      loc_rdata <= '0;
    end else begin
      if (loc_we)     regs[loc_addr] <= loc_wdata;
      if (wr_pending) regs[addr]     <= wr_byte;
      loc_rdata <= regs[loc_addr];
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: bit-banged SPI master, register-file model
// and a per-cycle monitor checking write strobes against expected commits.
module tb_spi_slave_regfile;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] status_in;
  logic       loc_we;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_active;

  always #5 clk = ~clk;

  spi_slave_regfile #(.NREGS(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .status_in(status_in),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_active(frame_active)
  );

  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          w0;
  logic [7:0]  mregs [32];
  logic [12:0] exp_wr [$];
  logic [12:0] wr_e;
  logic [7:0]  rx_log [4];
  logic [7:0]  rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected commit.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!spi_miso_oe) check("miso_low_when_disabled", spi_miso, 1'b0);
      if (wr_valid) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got strobe addr %0d data 0x%0h, expected none", wr_addr, wr_data);
        end else begin
          wr_e = exp_wr.pop_front();
          check("wr_addr", wr_addr, wr_e[12:8]);
          check("wr_data", wr_data, wr_e[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    tick(1);
    loc_we = 1'b0;
    mregs[a] = d;
  endtask

  task automatic loc_read(input logic [4:0] a);
    loc_addr = a;
    tick(1);
    check("loc_rdata", loc_rdata, mregs[a]);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      tick(8);
      spi_sclk = 1'b1;
      r[i] = spi_miso;
      tick(8);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_open(input logic [7:0] cmd);
    logic [7:0] r;
    spi_ss_n = 1'b0;
    tick(6);
    check("frame_active_open", frame_active, 1'b1);
    check("miso_oe_open", spi_miso_oe, 1'b1);
    spi_bits(cmd, 8, r);
    rx_log[0] = r;
    check("status_byte", r, status_in);
  endtask

  task automatic frame_close();
    tick(8);
    spi_ss_n = 1'b1;
    tick(6);
    check("frame_active_closed", frame_active, 1'b0);
    check("miso_oe_closed", spi_miso_oe, 1'b0);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    logic [4:0] a;
    logic [7:0] exp, r;
    d[0] = d0; d[1] = d1; d[2] = d2;
    a = cmd[7:3];
    frame_open(cmd);
    for (int k = 0; k < n; k++) begin
      if (cmd[1]) begin
        exp = 8'h00;
        exp_wr.push_back({a, d[k]});
        mregs[a] = d[k];
      end else begin
        exp = mregs[a];
      end
      spi_bits(d[k], 8, r);
      rx_log[k+1] = r;
      check("miso_byte", r, exp);
      a = a + 5'd1;
    end
    frame_close();
  endtask

  // Holds a local write until the SPI commit strobe, so both land on the same edge.
  task automatic collide(input logic [4:0] a, input logic [7:0] d, input logic spi_same);
    int n = 0;
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    while (!wr_valid && n < 3000) begin
      tick(1);
      n++;
    end
    loc_we = 1'b0;
    check("collide_commit_seen", n < 3000, 1'b1);
    if (!spi_same) mregs[a] = d;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    status_in = 8'h00; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 8'h00;

    // 1: reset and idle
    tick(1);
    check("rst_miso_oe", spi_miso_oe, 1'b0);
    check("rst_frame_active", frame_active, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("idle_miso_oe", spi_miso_oe, 1'b0);
    check("idle_frame_active", frame_active, 1'b0);
    for (int i = 0; i < 32; i++) loc_read(5'(i));

    // 2: write burst at address 17
    status_in = 8'h81;
    w0 = wr_seen;
    spi_frame(8'h8A, 3, 8'h11, 8'h22, 8'h33);
    check("burst_wr_count", wr_seen - w0, 3);
    loc_read(5'd18);
    check("reg18_literal", loc_rdata, 8'h22);
    loc_read(5'd17);
    loc_read(5'd19);
    check("reg19_literal", loc_rdata, 8'h33);

    // 3: read burst with status, wrapping past 31
    status_in = 8'h5A;
    loc_write(5'd30, 8'hA5);
    loc_write(5'd31, 8'h3C);
    w0 = wr_seen;
    spi_frame(8'hF0, 3, 8'h00, 8'h00, 8'h00);
    check("rd_status_literal", rx_log[0], 8'h5A);
    check("rd_byte0_literal", rx_log[1], 8'hA5);
    check("rd_byte1_literal", rx_log[2], 8'h3C);
    check("rd_byte2_literal", rx_log[3], 8'h00);
    check("rd_no_writes", wr_seen - w0, 0);

    // 4: abort after 5 data bits
    loc_write(5'd1, 8'h5C);
    w0 = wr_seen;
    spi_ss_n = 1'b0;
    tick(6);
    spi_bits(8'h0A, 8, rx);
    check("abort_status", rx, 8'h5A);
    spi_bits(8'hE7, 5, rx);
    tick(4);
    check("abort_oe_before", spi_miso_oe, 1'b1);
    spi_ss_n = 1'b1;
    tick(SYNC + 1);
    check("abort_oe_after", spi_miso_oe, 1'b0);
    check("abort_frame_after", frame_active, 1'b0);
    tick(20);
    check("abort_no_writes", wr_seen - w0, 0);
    loc_read(5'd1);
    check("reg1_literal", loc_rdata, 8'h5C);

    // 5: same-address collision (SPI wins), then different-address collision
    fork
      spi_frame(8'h22, 1, 8'h99, 8'h00, 8'h00);
      collide(5'd4, 8'h77, 1'b1);
    join
    loc_read(5'd4);
    check("reg4_literal", loc_rdata, 8'h99);
    fork
      spi_frame(8'h32, 1, 8'h5E, 8'h00, 8'h00);
      collide(5'd5, 8'h66, 1'b0);
    join
    loc_read(5'd5);
    check("reg5_literal", loc_rdata, 8'h66);
    loc_read(5'd6);
    check("reg6_literal", loc_rdata, 8'h5E);

    // 6: reset mid-frame
    loc_write(5'd2, 8'h44);
    loc_read(5'd2);
    spi_ss_n = 1'b0;
    tick(6);
    spi_bits(8'h12, 8, rx);
    spi_bits(8'hB4, 3, rx);
    reset_n = 1'b0;
    spi_ss_n = 1'b1;
    #1;
    check("mid_rst_miso", spi_miso, 1'b0);
    check("mid_rst_oe", spi_miso_oe, 1'b0);
    check("mid_rst_wr_valid", wr_valid, 1'b0);
    check("mid_rst_wr_addr", wr_addr, 5'd0);
    check("mid_rst_wr_data", wr_data, 8'h00);
    check("mid_rst_loc_rdata", loc_rdata, 8'h00);
    check("mid_rst_frame", frame_active, 1'b0);
    for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    exp_wr.delete();
    tick(3);
    reset_n = 1'b1;
    tick(3);
    loc_read(5'd2);
    check("reg2_cleared_literal", loc_rdata, 8'h00);
    loc_read(5'd30);
    status_in = 8'h3D;
    spi_frame(8'h12, 1, 8'hC3, 8'h00, 8'h00);
    loc_read(5'd2);
    check("reg2_after_literal", loc_rdata, 8'hC3);
    spi_frame(8'h10, 2, 8'h00, 8'h00, 8'h00);
    check("post_rd_status_literal", rx_log[0], 8'h3D);
    check("post_rd_byte0_literal", rx_log[1], 8'hC3);
    check("post_rd_byte1_literal", rx_log[2], 8'h00);

    tick(10);
    check("pending_writes_left", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
SPI mode-0 slave that emulates a MAX3421E-style register interface. It is the responder on the other end of the SoC's SPI master (MOSI/SCLK/SS_n driven by the master, MISO returned). It holds a 32 x 8 register file that the master reads and writes over SPI. Local FPGA logic sees SPI writes as strobes and can read and update the same registers. It is used as a bench and loopback target for the USB/SPI driver software.

Parameters:
NREGS, 32, number of 8-bit registers; address width is log2(NREGS), which is 5.
SYNC_STAGES, 2, synchronizer flops on sclk, mosi and ss_n.

Ports:
clk  in  1  system clock; must be at least 8x SCLK frequency.
reset_n  in  1  asynchronous active-low reset.
spi_sclk  in  1  SPI clock from master; idles low.
spi_mosi  in  1  master-out data, MSB first.
spi_ss_n  in  1  slave select, active low.
spi_miso  out  1  slave-out data.
spi_miso_oe  out  1  MISO output enable; the top level tri-states MISO when this is 0.
status_in  in  8  status byte shifted out during the command byte.
loc_we  in  1  local register write enable.
loc_addr  in  5  local read/write address.
loc_wdata  in  8  local write data.
loc_rdata  out  8  registered read of reg[loc_addr]; valid 1 cycle after loc_addr.
wr_valid  out  1  one-cycle pulse per SPI data byte written.
wr_addr  out  5  register address of that written byte.
wr_data  out  8  value of that written byte.
frame_active  out  1  high while a synchronized SS_n is low.

Behaviour:
- Reset (asynchronous, active low): all registers are cleared to 0.
  - spi_miso=0, spi_miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, loc_rdata=0, frame_active=0.
  - The FSM returns to IDLE and the bit counter returns to 0.
  - A reset mid-frame aborts the frame. No wr_valid is produced for a partial byte.
- Synchronization: sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - Rising and falling edges of sclk are detected from the last two synchronized samples.
  - MOSI is sampled on a synchronized rising edge. MISO is updated on a synchronized falling edge.
- FSM states: IDLE, CMD, DATA_WR, DATA_RD.
  - IDLE -> CMD on ss_n falling (synchronized).
    - spi_miso_oe goes to 1, frame_active goes to 1.
    - The shift-out register is loaded with status_in, and spi_miso drives bit 7 in the same cycle.
  - CMD: 8 rising edges shift in the command byte.
    - Bits [7:3] are the start address. Bit [1] = 1 means write, 0 means read. Bits [2] and [0] are ignored.
    - On the 8th rising edge, the address counter is loaded and the FSM moves to DATA_WR or DATA_RD.
    - For DATA_RD, reg[addr] is loaded into the shift-out register so it is ready for the next falling edge.
  - DATA_WR: each completed byte (8th rising edge) is handled in the next clk cycle.
    - reg[addr] is written with the byte.
    - wr_valid pulses for 1 cycle, with wr_addr=addr and wr_data=byte.
    - addr increments, wrapping from 31 to 0.
    - MISO shifts out 0x00 throughout.
  - DATA_RD: MSB-first shift of reg[addr].
    - After the 8th rising edge, addr increments (wrapping from 31 to 0) and reg[addr] for the new address is loaded.
    - The first falling edge after the load drives the new MSB.
- ss_n rises in any state: return to IDLE.
  - spi_miso_oe=0 and spi_miso=0.
  - Any partial byte is discarded; no write and no wr_valid.
  - Bytes already completed remain written.
- Bit counter: 3 bits, counts rising edges, and is reset to 0 on every ss_n falling edge.
- Local port:
  - loc_we writes reg[loc_addr] on the clock edge.
  - If an SPI write and loc_we hit the same address in the same cycle, the SPI write wins.
  - If they hit different addresses in the same cycle, both writes occur.
  - loc_rdata is registered and reflects any write committed in the previous cycle.
- SCLK edges while ss_n is high are ignored.

Test Plan:
1. Reset, then idle: spi_miso_oe=0, frame_active=0, wr_valid=0, loc_rdata=0 for every loc_addr from 0 to 31.
2. Write burst:
   - Stimulus: SS_n low, command 0x8A (address 17, write), data 0x11 0x22 0x33, SS_n high.
   - Required: 3 wr_valid pulses, with (addr 17, 0x11), (addr 18, 0x22), (addr 19, 0x33). loc_rdata at loc_addr=18 reads 0x22.
3. Read burst with status:
   - Stimulus: status_in=0x5A. Registers 30=0xA5 and 31=0x3C are preloaded via loc_we. Command 0xF0 (address 30, read), then 3 data bytes.
   - Required: MISO returns 0x5A during the command byte, then 0xA5, 0x3C, and 0x00 (address wrapped to reg 0). No wr_valid pulses.
4. Abort:
   - Stimulus: command 0x0A (address 1, write), then only 5 bits of data before SS_n rises.
   - Required: no wr_valid, reg 1 unchanged, spi_miso_oe=0 within SYNC_STAGES+1 cycles.
5. Collision:
   - Stimulus: loc_we to address 4 with 0x77 in the same cycle that an SPI write of 0x99 to address 4 commits.
   - Required: reg 4 = 0x99.
6. Reset mid-frame:
   - Stimulus: reset_n asserted after 3 data bits of a write to address 2 (reg 2 was 0x44).
   - Required: all outputs return to reset values and reg 2 = 0x00 (reset clears the file). The next frame behaves normally.
